// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_pkg
// Description : Shared state encoding and datapath select constants for the
//               parametrised cache controller.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EVICT = 2'd1,
        S_FILL  = 2'd2,
        S_WT_WR = 2'd3
    } state_t;

    localparam logic MRW_READ  = 1'b0;
    localparam logic MRW_WRITE = 1'b1;

    localparam logic SEL_CACHE = 1'b0;
    localparam logic SEL_MEM   = 1'b1;

endpackage : cache_ctrl_pkg
`default_nettype wire

// File: rtl/mem_wait_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_wait_ctr
// Description : Loadable down-counter that times one memory word phase.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wait_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    output logic         zero
);

    logic [W-1:0] r_cnt;

    // Saturates at zero so an idle counter always reports zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (ld) begin
            r_cnt <= ld_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign zero = (r_cnt == '0);

endmodule : mem_wait_ctr
`default_nettype wire

// File: rtl/cache_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : cache_ctrl_param
// Description : Cache controller FSM with multi-word line fill/evict, memory
//               wait states and write-back or write-through operation.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_ctrl_param
    import cache_ctrl_pkg::*;
#(
    parameter int MEM_WAIT   = 4,
    parameter int LINE_WORDS = 4,
    parameter int WRITE_BACK = 1,
    parameter int IDX_W      = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Strobe,
    input  logic             DRW,
    input  logic             M,
    input  logic             V,
    input  logic             D,
    output logic             DReady,
    output logic             W,
    output logic             SetD,
    output logic             ClrD,
    output logic             MStrobe,
    output logic             MRW,
    output logic             RSel,
    output logic             WSel,
    output logic [IDX_W-1:0] WordIdx,
    output logic             Busy
);

    localparam int              CW         = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0]   c_wait_ld  = CW'(MEM_WAIT - 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(LINE_WORDS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_next_idx;
    logic             r_first;
    logic             r_abort;
    logic             w_abort_nx;
    logic             w_ld;
    logic             w_zero;
    logic             w_hit;
    logic             w_last_word;

    logic w_dready, w_w, w_setd, w_clrd, w_mstrobe, w_mrw, w_rsel, w_wsel;

    // The counter is loaded on the cycle before each word phase, so it reads
    // MEM_WAIT-1 on the phase's first cycle and zero on its last.
    mem_wait_ctr #(
        .W (CW)
    ) u_wait (
        .clk    (clk),
        .reset  (reset),
        .ld     (w_ld),
        .ld_val (c_wait_ld),
        .zero   (w_zero)
    );

    assign w_hit       = M & V;
    assign w_last_word = (r_idx == c_last_idx);

    always_comb begin
        w_next     = r_state;
        w_next_idx = r_idx;
        w_abort_nx = r_abort;
        w_ld       = 1'b0;
        w_dready   = 1'b0;
        w_w        = 1'b0;
        w_setd     = 1'b0;
        w_clrd     = 1'b0;
        w_mstrobe  = 1'b0;
        w_mrw      = MRW_READ;
        w_rsel     = SEL_CACHE;
        w_wsel     = SEL_CACHE;

        case (r_state)
            S_IDLE: begin
                w_abort_nx = 1'b0;
                w_next_idx = '0;
                if (Strobe) begin
                    if (!DRW) begin
                        if (w_hit) begin
                            w_dready = 1'b1;
                        end else if ((WRITE_BACK != 0) && V && D) begin
                            w_next = S_EVICT;
                            w_ld   = 1'b1;
                        end else begin
                            w_next = S_FILL;
                            w_ld   = 1'b1;
                        end
                    end else if (WRITE_BACK != 0) begin
                        if (w_hit) begin
                            w_w      = 1'b1;
                            w_setd   = 1'b1;
                            w_dready = 1'b1;
                        end else if (V && D) begin
                            w_next = S_EVICT;
                            w_ld   = 1'b1;
                        end else begin
                            w_next = S_FILL;
                            w_ld   = 1'b1;
                        end
                    end else begin
                        w_w    = w_hit;
                        w_next = S_WT_WR;
                        w_ld   = 1'b1;
                    end
                end
            end

            S_EVICT: begin
                w_mrw      = MRW_WRITE;
                w_mstrobe  = r_first;
                w_abort_nx = r_abort | ~Strobe;
                if (w_zero) begin
                    if (w_last_word) begin
                        // A withdrawn request still finishes the write-back but skips the refill.
                        w_next_idx = '0;
                        w_next     = w_abort_nx ? S_IDLE : S_FILL;
                        w_ld       = ~w_abort_nx;
                    end else begin
                        w_next_idx = r_idx + 1'b1;
                        w_ld       = 1'b1;
                    end
                end
            end

            S_FILL: begin
                w_mstrobe = r_first;
                if (w_zero) begin
                    w_w    = 1'b1;
                    w_wsel = SEL_MEM;
                    if (w_last_word) begin
                        w_clrd     = 1'b1;
                        w_next_idx = '0;
                        w_next     = S_IDLE;
                    end else begin
                        w_next_idx = r_idx + 1'b1;
                        w_ld       = 1'b1;
                    end
                end
            end

            S_WT_WR: begin
                w_mrw     = MRW_WRITE;
                w_mstrobe = r_first;
                if (w_zero) begin
                    w_dready = 1'b1;
                    w_next   = S_IDLE;
                end
            end

            default: begin
                w_next     = S_IDLE;
                w_next_idx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_first <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_next;
            r_idx   <= w_next_idx;
            r_first <= w_ld;
            r_abort <= w_abort_nx;
        end
    end

    // Outputs are forced low during reset so an aborted transfer stops at once.
    assign DReady  = w_dready  & ~reset;
    assign W       = w_w       & ~reset;
    assign SetD    = w_setd    & ~reset;
    assign ClrD    = w_clrd    & ~reset;
    assign MStrobe = w_mstrobe & ~reset;
    assign MRW     = w_mrw     & ~reset;
    assign RSel    = w_rsel    & ~reset;
    assign WSel    = w_wsel    & ~reset;
    assign WordIdx = reset ? '0 : r_idx;
    assign Busy    = (r_state != S_IDLE) & ~reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (MEM_WAIT >= 1)
                else $error("cache_ctrl_param: MEM_WAIT must be >= 1");
            assert ((LINE_WORDS >= 1) && ((LINE_WORDS & (LINE_WORDS - 1)) == 0))
                else $error("cache_ctrl_param: LINE_WORDS must be a power of 2");
        end
    end

endmodule : cache_ctrl_param
`default_nettype wire

// File: tb/tb_cache_ctrl_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_ctrl_param
// Description : Directed self-checking bench for three controller configs:
//               write-back default, write-through, and single-word/single-wait.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_ctrl_param;

    logic clk = 1'b0;
    logic reset, Strobe, DRW, M, V, D;

    // Output vector: {DReady, W, SetD, ClrD, MStrobe, MRW, RSel, WSel, Busy}
    logic [8:0] wb_o, wt_o, mn_o;
    logic [1:0] wb_idx, wt_idx;
    logic [0:0] mn_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_ctrl_param u_wb (
        .clk(clk), .reset(reset), .Strobe(Strobe), .DRW(DRW), .M(M), .V(V), .D(D),
        .DReady(wb_o[8]), .W(wb_o[7]), .SetD(wb_o[6]), .ClrD(wb_o[5]),
        .MStrobe(wb_o[4]), .MRW(wb_o[3]), .RSel(wb_o[2]), .WSel(wb_o[1]),
        .WordIdx(wb_idx), .Busy(wb_o[0])
    );

    cache_ctrl_param #(.WRITE_BACK(0)) u_wt (
        .clk(clk), .reset(reset), .Strobe(Strobe), .DRW(DRW), .M(M), .V(V), .D(D),
        .DReady(wt_o[8]), .W(wt_o[7]), .SetD(wt_o[6]), .ClrD(wt_o[5]),
        .MStrobe(wt_o[4]), .MRW(wt_o[3]), .RSel(wt_o[2]), .WSel(wt_o[1]),
        .WordIdx(wt_idx), .Busy(wt_o[0])
    );

    cache_ctrl_param #(.MEM_WAIT(1), .LINE_WORDS(1)) u_mn (
        .clk(clk), .reset(reset), .Strobe(Strobe), .DRW(DRW), .M(M), .V(V), .D(D),
        .DReady(mn_o[8]), .W(mn_o[7]), .SetD(mn_o[6]), .ClrD(mn_o[5]),
        .MStrobe(mn_o[4]), .MRW(mn_o[3]), .RSel(mn_o[2]), .WSel(mn_o[1]),
        .WordIdx(mn_idx), .Busy(mn_o[0])
    );

    task automatic chk(input string tag, input int cyc, input logic [10:0] obs,
                       input logic [10:0] exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
            end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        Strobe = 1'b0;
        tick();
        reset  = 1'b0;
    endtask

    // Expected fill word-phase outputs (MEM_WAIT=4, LINE_WORDS=4), k = cycles into fill.
    function automatic logic [10:0] fill_exp(input int k);
        logic [1:0] idx;
        logic       ms, wr, clr;
        idx = 2'(k / 4);
        ms  = (k % 4) == 0;
        wr  = (k % 4) == 3;
        clr = wr && (idx == 2'd3);
        return {idx, 1'b0, wr, 1'b0, clr, ms, 1'b0, 1'b0, wr, 1'b1};
    endfunction

    function automatic logic [10:0] evict_exp(input int k);
        logic [1:0] idx;
        logic       ms;
        idx = 2'(k / 4);
        ms  = (k % 4) == 0;
        return {idx, 1'b0, 1'b0, 1'b0, 1'b0, ms, 1'b1, 1'b0, 1'b0, 1'b1};
    endfunction

    function automatic logic [10:0] wt_exp(input int c);
        logic ms, dr;
        ms = (c == 1);
        dr = (c == 4);
        return {2'b00, dr, 1'b0, 1'b0, 1'b0, ms, 1'b1, 1'b0, 1'b0, 1'b1};
    endfunction

    initial begin
        // Reset with a would-be read hit on the inputs: outputs must stay low.
        reset = 1'b1; Strobe = 1'b1; DRW = 1'b0; M = 1'b1; V = 1'b1; D = 1'b0;
        tick();
        #2;
        chk("reset_wb", 0, {wb_idx, wb_o}, 11'd0);
        chk("reset_wt", 0, {wt_idx, wt_o}, 11'd0);
        tick();
        reset = 1'b0;

        // Read hit: DReady in cycle 0, no memory activity.
        #2;
        chk("rd_hit", 0, {wb_idx, wb_o}, {2'b00, 9'b1_0000_0000});
        tick();
        Strobe = 1'b0;
        #2;
        chk("rd_hit_idle", 1, {wb_idx, wb_o}, 11'd0);

        // Clean read miss: fill cycles 1..16, hit served at 17.
        do_reset();
        Strobe = 1'b1; DRW = 1'b0; M = 1'b0; V = 1'b0; D = 1'b0;
        #2;
        chk("rdmiss_c0", 0, {wb_idx, wb_o}, 11'd0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            #2;
            chk("rdmiss_fill", c, {wb_idx, wb_o}, fill_exp(c - 1));
        end
        tick();
        M = 1'b1; V = 1'b1;
        #2;
        chk("rdmiss_done", 17, {wb_idx, wb_o}, {2'b00, 9'b1_0000_0000});
        tick();
        Strobe = 1'b0;

        // Dirty write miss: evict 1..16, fill 17..32, write hit at 33.
        do_reset();
        Strobe = 1'b1; DRW = 1'b1; M = 1'b0; V = 1'b1; D = 1'b1;
        #2;
        chk("wrdirty_c0", 0, {wb_idx, wb_o}, 11'd0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            #2;
            chk("wrdirty_evict", c, {wb_idx, wb_o}, evict_exp(c - 1));
        end
        for (int c = 17; c <= 32; c++) begin
            tick();
            #2;
            chk("wrdirty_fill", c, {wb_idx, wb_o}, fill_exp(c - 17));
        end
        tick();
        M = 1'b1; D = 1'b0;
        #2;
        chk("wrdirty_hit", 33, {wb_idx, wb_o}, {2'b00, 9'b1_1100_0000});
        tick();
        Strobe = 1'b0;

        // Write-through write hit.
        do_reset();
        Strobe = 1'b1; DRW = 1'b1; M = 1'b1; V = 1'b1; D = 1'b0;
        #2;
        chk("wt_hit_c0", 0, {wt_idx, wt_o}, {2'b00, 9'b0_1000_0000});
        for (int c = 1; c <= 4; c++) begin
            tick();
            #2;
            chk("wt_hit_phase", c, {wt_idx, wt_o}, wt_exp(c));
        end
        tick();
        Strobe = 1'b0;
        #2;
        chk("wt_hit_idle", 5, {wt_idx, wt_o}, 11'd0);

        // Write-through write miss: no cache write.
        do_reset();
        Strobe = 1'b1; DRW = 1'b1; M = 1'b0; V = 1'b1; D = 1'b0;
        #2;
        chk("wt_miss_c0", 0, {wt_idx, wt_o}, 11'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            #2;
            chk("wt_miss_phase", c, {wt_idx, wt_o}, wt_exp(c));
        end
        tick();
        Strobe = 1'b0;
        #2;
        chk("wt_miss_idle", 5, {wt_idx, wt_o}, 11'd0);

        // Strobe dropped at cycle 6 of a clean miss: fill completes, no DReady.
        do_reset();
        Strobe = 1'b1; DRW = 1'b0; M = 1'b0; V = 1'b0; D = 1'b0;
        #2;
        chk("drop_c0", 0, {wb_idx, wb_o}, 11'd0);
        for (int c = 1; c <= 16; c++) begin
            tick();
            if (c == 6) Strobe = 1'b0;
            #2;
            chk("drop_fill", c, {wb_idx, wb_o}, fill_exp(c - 1));
        end
        for (int c = 17; c <= 19; c++) begin
            tick();
            #2;
            chk("drop_idle", c, {wb_idx, wb_o}, 11'd0);
        end

        // Reset at cycle 3 of an eviction.
        do_reset();
        Strobe = 1'b1; DRW = 1'b1; M = 1'b0; V = 1'b1; D = 1'b1;
        #2;
        chk("rst_evict_c0", 0, {wb_idx, wb_o}, 11'd0);
        for (int c = 1; c <= 2; c++) begin
            tick();
            #2;
            chk("rst_evict_run", c, {wb_idx, wb_o}, evict_exp(c - 1));
        end
        tick();
        reset = 1'b1;
        #2;
        chk("rst_evict_asserted", 3, {wb_idx, wb_o}, 11'd0);
        tick();
        reset  = 1'b0;
        Strobe = 1'b0;
        #2;
        chk("rst_evict_idle", 4, {wb_idx, wb_o}, 11'd0);
        for (int c = 5; c <= 12; c++) begin
            tick();
            #2;
            chk("rst_evict_quiet", c, {wb_idx, wb_o}, 11'd0);
        end

        // MEM_WAIT=1, LINE_WORDS=1 clean miss: single fill cycle, DReady at 2.
        do_reset();
        Strobe = 1'b1; DRW = 1'b0; M = 1'b0; V = 1'b0; D = 1'b0;
        #2;
        chk("min_c0", 0, {1'b0, mn_idx, mn_o}, 11'd0);
        tick();
        #2;
        chk("min_fill", 1, {1'b0, mn_idx, mn_o}, {2'b00, 9'b0_1011_0011});
        tick();
        M = 1'b1; V = 1'b1;
        #2;
        chk("min_done", 2, {1'b0, mn_idx, mn_o}, {2'b00, 9'b1_0000_0000});
        tick();
        Strobe = 1'b0;
        #2;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_cache_ctrl_param
`default_nettype wire
